// File: rtl/parking_keypad_front.sv
// Keypad front end for user_proj_parking: assembles a two-digit passcode, turns the raw exit button
// into a single request, and holds off new requests while the controller runs. Macro LOCKOUT_EN adds failed-entry lockout.
module parking_keypad_front #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int BUSY_CYCLES    = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid_i,
    input  logic [3:0] key_nibble_i,
    input  logic       key_clear_i,
    input  logic       key_enter_i,
    input  logic       exit_btn_i,
    input  logic       entry_gate_open_i,
    output logic [7:0] passcode_out_o,
    output logic       enter_req_o,
    output logic       exit_req_o,
    output logic [1:0] digits_entered_o,
    output logic       busy_o,
    output logic       locked_o
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WT_W = $clog2(BUSY_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(BUSY_CYCLES - 1);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_REQ_ENTRY,
        S_REQ_EXIT,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      code_q, code_d;
    logic [1:0]      digits_q, digits_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [WT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            seen_q, seen_d;
    logic            is_entry_q, is_entry_d;
    logic            exit_pend_q, exit_pend_d;
    logic [7:0]      pass_q, pass_d;
    logic            enter_req_q, exit_req_q, busy_q;

    logic exit_sync1_q, exit_sync2_q, exit_prev_q;
    logic exit_edge;
    logic key_block;
    logic valid_eff, clear_eff, enter_eff;
    logic wait_last, entry_done, entry_ok;

    assign exit_edge  = exit_sync2_q & ~exit_prev_q;
    assign valid_eff  = key_valid_i & ~key_block;
    assign clear_eff  = key_clear_i & ~key_block;
    assign enter_eff  = key_enter_i & ~key_block;
    assign wait_last  = (state_q == S_WAIT) && (wait_cnt_q == WT_LAST);
    assign entry_done = wait_last & is_entry_q;
    assign entry_ok   = seen_q | entry_gate_open_i;

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        digits_d    = digits_q;
        to_cnt_d    = to_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        seen_d      = seen_q;
        is_entry_d  = is_entry_q;
        exit_pend_d = exit_pend_q;
        pass_d      = pass_q;

        case (state_q)
            S_COLLECT: begin
                if (clear_eff) begin
                    code_d   = '0;
                    digits_d = '0;
                    to_cnt_d = '0;
                end else if (enter_eff) begin
                    to_cnt_d = '0;
                    if (digits_q == 2'd2) begin
                        state_d = S_REQ_ENTRY;
                        pass_d  = code_q;
                    end else begin
                        code_d   = '0;
                        digits_d = '0;
                    end
                end else if (valid_eff) begin
                    code_d   = {code_q[3:0], key_nibble_i};
                    to_cnt_d = '0;
                    if (digits_q != 2'd2) begin
                        digits_d = digits_q + 2'd1;
                    end
                end else begin
                    // A partial code left idle too long is discarded.
                    if (digits_q != 2'd0) begin
                        if (to_cnt_q == TO_LAST) begin
                            code_d   = '0;
                            digits_d = '0;
                            to_cnt_d = '0;
                        end else begin
                            to_cnt_d = to_cnt_q + TO_W'(1);
                        end
                    end
                    if (exit_pend_q) begin
                        state_d     = S_REQ_EXIT;
                        exit_pend_d = 1'b0;
                    end
                end
            end
            S_REQ_ENTRY: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
                seen_d     = 1'b0;
                is_entry_d = 1'b1;
            end
            S_REQ_EXIT: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
                seen_d     = 1'b0;
                is_entry_d = 1'b0;
            end
            S_WAIT: begin
                seen_d = seen_q | entry_gate_open_i;
                if (wait_cnt_q == WT_LAST) begin
                    state_d  = S_COLLECT;
                    code_d   = '0;
                    digits_d = '0;
                    to_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WT_W'(1);
                end
            end
            default: state_d = S_COLLECT;
        endcase

        // A fresh edge must survive even the cycle that consumes the previous one.
        if (exit_edge) begin
            exit_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_COLLECT;
            code_q       <= '0;
            digits_q     <= '0;
            to_cnt_q     <= '0;
            wait_cnt_q   <= '0;
            seen_q       <= 1'b0;
            is_entry_q   <= 1'b0;
            exit_pend_q  <= 1'b0;
            pass_q       <= '0;
            enter_req_q  <= 1'b0;
            exit_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            exit_sync1_q <= 1'b0;
            exit_sync2_q <= 1'b0;
            exit_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            digits_q     <= digits_d;
            to_cnt_q     <= to_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            seen_q       <= seen_d;
            is_entry_q   <= is_entry_d;
            exit_pend_q  <= exit_pend_d;
            pass_q       <= pass_d;
            enter_req_q  <= (state_d == S_REQ_ENTRY);
            exit_req_q   <= (state_d == S_REQ_EXIT);
            busy_q       <= (state_d != S_COLLECT);
            exit_sync1_q <= exit_btn_i;
            exit_sync2_q <= exit_sync1_q;
            exit_prev_q  <= exit_sync2_q;
        end
    end

`ifdef LOCKOUT_EN
    localparam int FC_W = $clog2(MAX_FAILS + 1);
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [FC_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic            locked_q, locked_d;

    // Only entry requests count; a gate seen open at any point during WAIT is a success.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (locked_q) begin
            if (lock_cnt_q == LK_W'(LOCKOUT_CYCLES - 1)) begin
                locked_d   = 1'b0;
                fail_cnt_d = '0;
                lock_cnt_d = '0;
            end else begin
                lock_cnt_d = lock_cnt_q + LK_W'(1);
            end
        end else if (entry_done) begin
            if (entry_ok) begin
                fail_cnt_d = '0;
            end else if (fail_cnt_q == FC_W'(MAX_FAILS - 1)) begin
                fail_cnt_d = FC_W'(MAX_FAILS);
                locked_d   = 1'b1;
                lock_cnt_d = '0;
            end else begin
                fail_cnt_d = fail_cnt_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_cnt_q <= '0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign key_block = locked_q;
    assign locked_o  = locked_q;
`else
    logic unused_lock_inputs;
    assign unused_lock_inputs = entry_done ^ entry_ok;
    assign key_block = 1'b0;
    assign locked_o  = 1'b0;
`endif

    assign passcode_out_o   = pass_q;
    assign enter_req_o      = enter_req_q;
    assign exit_req_o       = exit_req_q;
    assign digits_entered_o = digits_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_parking_keypad_front.sv
// Directed bench for parking_keypad_front: digit assembly, request timing, exit handling, reset and lockout.
`timescale 1ns/1ps
module tb_parking_keypad_front;
    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid, key_clear, key_enter, exit_btn, gate;
    logic [3:0] key_nibble;
    logic [7:0] passcode;
    logic       enter_req, exit_req, busy, locked;
    logic [1:0] digits;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_enter, n_exit, n_busy, first_exit, first_idle;
    int lock_on, lock_off;

    always #5 clk = ~clk;

    parking_keypad_front dut (
        .clk              (clk),
        .reset            (reset),
        .key_valid_i      (key_valid),
        .key_nibble_i     (key_nibble),
        .key_clear_i      (key_clear),
        .key_enter_i      (key_enter),
        .exit_btn_i       (exit_btn),
        .entry_gate_open_i(gate),
        .passcode_out_o   (passcode),
        .enter_req_o      (enter_req),
        .exit_req_o       (exit_req),
        .digits_entered_o (digits),
        .busy_o           (busy),
        .locked_o         (locked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic key(input logic [3:0] d);
        key_valid  = 1'b1;
        key_nibble = d;
        step(1);
        key_valid  = 1'b0;
    endtask

    task automatic enter();
        key_enter = 1'b1;
        step(1);
        key_enter = 1'b0;
    endtask

    task automatic clear_obs();
        n_enter = 0; n_exit = 0; n_busy = 0; first_exit = 0; first_idle = 0;
    endtask

    task automatic observe(input int n);
        for (int i = 1; i <= n; i++) begin
            step(1);
            if (enter_req) n_enter++;
            if (exit_req) begin
                n_exit++;
                if (first_exit == 0) first_exit = i;
            end
            if (busy) n_busy++;
            else if (first_idle == 0) first_idle = i;
        end
    endtask

    task automatic do_entry(input string tag);
        key(4'h1);
        key(4'h2);
        enter();
        check(tag, enter_req, 1'b1);
        observe(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_clear = 1'b0; key_enter = 1'b0;
        key_nibble = 4'h0; exit_btn = 1'b0; gate = 1'b1;
        clear_obs();
        step(2);
        check("rst_passcode", passcode, 8'h00);
        check("rst_enter", enter_req, 1'b0);
        check("rst_exit", exit_req, 1'b0);
        check("rst_digits", digits, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_locked", locked, 1'b0);
        reset = 1'b0;
        step(1);
        check("post_rst_busy", busy, 1'b0);

        // Two F digits then enter.
        key(4'hF);
        check("ff_digits1", digits, 2'd1);
        key(4'hF);
        check("ff_digits2", digits, 2'd2);
        enter();
        check("ff_enter_req", enter_req, 1'b1);
        check("ff_passcode", passcode, 8'hFF);
        check("ff_busy_req", busy, 1'b1);
        check("ff_no_exit", exit_req, 1'b0);
        clear_obs();
        observe(8);
        check("ff_busy_wait", n_busy, 4);
        check("ff_idle_at", first_idle, 5);
        check("ff_single_pulse", n_enter, 0);
        check("ff_digits_done", digits, 2'd0);
        check("ff_pass_held", passcode, 8'hFF);

        // Third digit drops the oldest.
        key(4'h1); key(4'h2); key(4'h3);
        check("d3_digits", digits, 2'd2);
        enter();
        check("d3_enter_req", enter_req, 1'b1);
        check("d3_passcode", passcode, 8'h23);
        observe(8);

        // Enter with a single digit.
        key(4'h5);
        enter();
        check("short_no_req", enter_req, 1'b0);
        check("short_digits", digits, 2'd0);
        check("short_busy", busy, 1'b0);

        // Clear, and clear beating a same-cycle digit.
        key(4'h3); key(4'h4);
        key_clear = 1'b1; key_valid = 1'b1; key_nibble = 4'h9;
        step(1);
        key_clear = 1'b0; key_valid = 1'b0;
        check("clear_digits", digits, 2'd0);
        enter();
        check("clear_no_req", enter_req, 1'b0);

        // Idle timeout.
        key(4'h7);
        step(254);
        check("to_before", digits, 2'd1);
        step(1);
        check("to_after", digits, 2'd0);

        // Exit button held 10 cycles.
        clear_obs();
        exit_btn = 1'b1;
        observe(10);
        exit_btn = 1'b0;
        observe(8);
        check("exit_pulses", n_exit, 1);
        check("exit_latency_ok", (first_exit >= 3 && first_exit <= 4), 1'b1);
        check("exit_busy", n_busy, 5);
        check("exit_no_enter", n_enter, 0);

        // Exit edge arriving during WAIT.
        key(4'hA); key(4'hB);
        enter();
        clear_obs();
        exit_btn = 1'b1;
        observe(12);
        exit_btn = 1'b0;
        check("wexit_pulses", n_exit, 1);
        check("wexit_idle_at", first_idle, 5);
        check("wexit_after_wait", first_exit - first_idle, 1);
        observe(8);

        // Entry and pending exit due in the same cycle.
        key(4'h6); key(4'h9);
        exit_btn = 1'b1;
        step(3);
        check("both_not_yet", exit_req, 1'b0);
        key_enter = 1'b1;
        step(1);
        key_enter = 1'b0;
        exit_btn = 1'b0;
        check("both_enter_first", enter_req, 1'b1);
        check("both_exit_held", exit_req, 1'b0);
        check("both_passcode", passcode, 8'h69);
        clear_obs();
        observe(10);
        check("both_exit_pulses", n_exit, 1);
        check("both_exit_after_wait", first_exit - first_idle, 1);

        // Reset in the middle of a request drops the pending exit.
        key(4'h1); key(4'h2);
        enter();
        exit_btn = 1'b1;
        step(3);
        exit_btn = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_passcode", passcode, 8'h00);
        check("mid_rst_digits", digits, 2'd0);
        step(2);
        reset = 1'b0;
        clear_obs();
        observe(10);
        check("mid_rst_exit_lost", n_exit, 0);
        check("mid_rst_idle", n_busy, 0);

        // Rejected entries (gate never opens).
        gate = 1'b0;
`ifdef LOCKOUT_EN
        do_entry("lk_req1");
        do_entry("lk_req2");
        check("lk_two_fails", locked, 1'b0);
        gate = 1'b1;
        do_entry("lk_success");
        gate = 1'b0;
        do_entry("lk_req3");
        do_entry("lk_req4");
        check("lk_success_clears", locked, 1'b0);
        key(4'h1); key(4'h2);
        enter();
        for (int i = 0; i < 10 && !locked; i++) step(1);
        check("lk_set", locked, 1'b1);
        lock_on = cyc;
        key(4'h5);
        check("lk_key_ignored", digits, 2'd0);
        enter();
        check("lk_enter_ignored", enter_req, 1'b0);
        clear_obs();
        exit_btn = 1'b1;
        observe(6);
        exit_btn = 1'b0;
        observe(6);
        check("lk_exit_served", n_exit, 1);
        check("lk_still_locked", locked, 1'b1);
        for (int i = 0; i < 1200 && locked; i++) step(1);
        lock_off = cyc;
        check("lk_released", locked, 1'b0);
        check("lk_duration", lock_off - lock_on, 1023);
        do_entry("lk_after_req");
        check("lk_count_reset", locked, 1'b0);
`else
        do_entry("nolk_req1");
        do_entry("nolk_req2");
        do_entry("nolk_req3");
        check("nolk_unlocked", locked, 1'b0);
        do_entry("nolk_req4");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
